sram_bus_arbiter: RTL



---
 rtl/sram_bus_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the fetch-stage
// instruction port and the mem-stage data port. One transaction is in flight
// at a time, data has fixed priority, and fetches can be squashed before or
// after the bus accepts them.
module sram_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_cancel,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_done,
  output logic          inst_stall,

  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_done,
  output logic          data_stall,

  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [3:0]    bus_wstrb,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          cancelled_q, cancelled_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_wr_q, bus_wr_d;
  logic [1:0]    bus_size_q, bus_size_d;
  logic [3:0]    bus_wstrb_q, bus_wstrb_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic          inst_done_q, inst_done_d;
  logic          data_done_q, data_done_d;
  logic          complete;
  logic          inst_killed;

  // Next-state logic: grant in IDLE, hand-shake in ADDR/RESP, then route the response to its owner
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancelled_d  = cancelled_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    complete     = 1'b0;
    // A fetch is dead if it was squashed earlier or is being squashed right now.
    inst_killed  = cancelled_q | inst_cancel;

    case (state_q)
      IDLE: begin
        cancelled_d = 1'b0;
        // A port whose done pulse is high this cycle is still holding its old
        // request, so it must not be granted again.
        if (data_req && !data_done_q) begin
          owner_d     = OWN_DATA;
          bus_req_d   = 1'b1;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_wstrb_d = data_wr ? data_wstrb : 4'b0000;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          state_d     = ADDR;
        end else if (inst_req && !inst_cancel && !inst_done_q) begin
          owner_d     = OWN_INST;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_size_d  = 2'd2;
          bus_wstrb_d = 4'b0000;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
          state_d     = ADDR;
        end
      end

      ADDR: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          if (owner_q == OWN_INST && inst_cancel) begin
            cancelled_d = 1'b1;
          end
          if (bus_data_ok) begin
            complete    = 1'b1;
            cancelled_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = RESP;
          end
        end else if (owner_q == OWN_INST && inst_cancel) begin
          // Not yet accepted: simply withdraw the fetch.
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      RESP: begin
        if (bus_data_ok) begin
          complete    = 1'b1;
          cancelled_d = 1'b0;
          state_d     = IDLE;
        end else if (owner_q == OWN_INST && inst_cancel) begin
          cancelled_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      if (owner_q == OWN_DATA) begin
        data_done_d = 1'b1;
        if (!bus_wr_q) begin
          data_rdata_d = bus_rdata;
        end
      end else if (!inst_killed) begin
        inst_done_d  = 1'b1;
        inst_rdata_d = bus_rdata;
      end
    end
  end

  // State and output registers; reset drops any outstanding transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      cancelled_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_wstrb_q  <= 4'b0000;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cancelled_q  <= cancelled_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_size   = bus_size_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;

  // Stalls must respond in the same cycle the request rises.
  assign inst_stall = inst_req & ~inst_done_q;
  assign data_stall = data_req & ~data_done_q;

endmodule
